// File: rtl/clz_normalize_shifter.sv
// clz_normalize_shifter
// Iterative log-step shifter driven by a leading-zero count. Mode 00/11
// shifts left (normalize), 01 shifts right logically and 10 shifts right
// arithmetically. Five stages (16,8,4,2,1) run one per cycle, so every
// request takes the same time from accept to done, whatever the count.
// WIDTH is fixed at 32; the stage table below assumes a 5-bit count.

module clz_normalize_shifter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] data_in,
    input  logic [5:0]       shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out,
    output logic             sat
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [2:0]       k;        // current stage index, 0..4
    logic [WIDTH-1:0] work;     // working operand
    logic [4:0]       cnt;      // captured count (low five bits)
    logic             left_r;   // 1: shift left, 0: shift right
    logic             fill_r;   // bit shifted into vacated positions
    logic             sat_r;    // captured count was 32 or more

    logic             left_in;
    logic             fill_in;

    logic [4:0]         stage_amt;
    logic               stage_en;
    logic [2*WIDTH-1:0] right_ext;
    logic [WIDTH-1:0]   left_val;
    logic [WIDTH-1:0]   right_val;
    logic [WIDTH-1:0]   stage_out;

    // Decode direction and fill bit for a request presented on the inputs
    always_comb begin
        left_in = (mode == 2'b00) || (mode == 2'b11);
        fill_in = (mode == 2'b10) && data_in[WIDTH-1];
    end

    // Select the stage distance and whether the count enables it
    always_comb begin
        stage_amt = 5'd1;
        stage_en  = 1'b0;
        case (k)
            3'd0: begin stage_amt = 5'd16; stage_en = cnt[4]; end
            3'd1: begin stage_amt = 5'd8;  stage_en = cnt[3]; end
            3'd2: begin stage_amt = 5'd4;  stage_en = cnt[2]; end
            3'd3: begin stage_amt = 5'd2;  stage_en = cnt[1]; end
            default: begin stage_amt = 5'd1; stage_en = cnt[0]; end
        endcase
    end

    // One shift stage: right shifts pull the fill bit in from a
    // double-width extension, left shifts always vacate with zeros
    always_comb begin
        right_ext = {{WIDTH{fill_r}}, work} >> stage_amt;
        right_val = right_ext[WIDTH-1:0];
        left_val  = work << stage_amt;
        if (sat_r) begin
            // a saturated count leaves nothing but fill; forcing it on every
            // stage is the same as loading it once at stage 0 and holding
            stage_out = {WIDTH{fill_r}};
        end else if (!stage_en) begin
            stage_out = work;
        end else if (left_r) begin
            stage_out = left_val;
        end else begin
            stage_out = right_val;
        end
    end

    // Control FSM with registered busy/done/result outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            k        <= '0;
            work     <= '0;
            cnt      <= '0;
            left_r   <= 1'b0;
            fill_r   <= 1'b0;
            sat_r    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            data_out <= '0;
            sat      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        work   <= data_in;
                        cnt    <= shamt[4:0];
                        left_r <= left_in;
                        fill_r <= fill_in;
                        sat_r  <= shamt[5];
                        k      <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    work <= stage_out;
                    if (k == 3'd4) begin
                        data_out <= stage_out;
                        sat      <= sat_r;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        k <= k + 3'd1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clz_normalize_shifter.sv
// tb_clz_normalize_shifter
// Scoreboarded bench: stimulus pushes expected results (from an arithmetic
// reference model) with their due cycle; a monitor checks busy/done/result
// each cycle against the scoreboard.

module tb_clz_normalize_shifter;

    logic        clk;
    logic        clk_en;
    logic        rst_n;
    logic        start;
    logic [1:0]  mode;
    logic [31:0] data_in;
    logic [5:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] data_out;
    logic        sat;

    clz_normalize_shifter #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mode     (mode),
        .data_in  (data_in),
        .shamt    (shamt),
        .busy     (busy),
        .done     (done),
        .data_out (data_out),
        .sat      (sat)
    );

    typedef struct {
        logic [31:0] d;
        logic        s;
        int unsigned c;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          fails = 0;
    logic [31:0] mdata = '0;
    logic        msat = 1'b0;

    // Clock toggles only while clk_en is set, so it can be frozen low
    initial begin
        clk    = 1'b0;
        clk_en = 1'b1;
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain shift arithmetic on the whole count
    function automatic logic [31:0] ref_shift(input logic [1:0] m, input logic [31:0] d,
                                              input logic [5:0] sh);
        logic fill;
        fill = (m == 2'b10) ? d[31] : 1'b0;
        if (sh >= 6'd32) return {32{fill}};
        case (m)
            2'b01:   return d >> sh;
            2'b10:   return 32'($signed(d) >>> sh);
            default: return d << sh;
        endcase
    endfunction

    // Monitor: one set of checks per clock, one time unit after the edge
    initial begin
        logic rst_seen;
        logic exp_busy;
        logic exp_done;
        forever begin
            @(posedge clk);
            rst_seen = !rst_n;
            #1;
            cyc++;
            if (rst_seen) begin
                q.delete();
                mdata = '0;
                msat  = 1'b0;
            end
            exp_busy = 1'b0;
            exp_done = 1'b0;
            if (q.size() > 0) begin
                if (cyc == q[0].c) begin
                    exp_done = 1'b1;
                    mdata    = q[0].d;
                    msat     = q[0].s;
                end else if (cyc + 5 >= q[0].c) begin
                    exp_busy = 1'b1;
                end
            end
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("done", 32'(done), 32'(exp_done));
            chk("data_out", data_out, mdata);
            chk("sat", 32'(sat), 32'(msat));
            if (exp_done) void'(q.pop_front());
        end
    end

    // Present a request for one cycle (cycle 0); returns at cycle 1
    task automatic issue(input logic [1:0] m, input logic [31:0] d, input logic [5:0] sh);
        exp_t e;
        @(negedge clk);
        start   = 1'b1;
        mode    = m;
        data_in = d;
        shamt   = sh;
        e.d = ref_shift(m, d, sh);
        e.s = (sh >= 6'd32);
        e.c = cyc + 6;
        q.push_back(e);
        @(negedge clk);
        start   = 1'b0;
        mode    = 2'($urandom);
        data_in = $urandom;
        shamt   = 6'($urandom);
    endtask

    // Full operation; returns in the done cycle so a following issue is back-to-back
    task automatic do_op(input logic [1:0] m, input logic [31:0] d, input logic [5:0] sh);
        issue(m, d, sh);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        logic [31:0] held;
        logic [5:0]  rs;
        rst_n   = 1'b0;
        start   = 1'b0;
        mode    = 2'b00;
        data_in = '0;
        shamt   = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // directed cases
        do_op(2'b00, 32'h0000_1234, 6'd19);
        @(negedge clk);
        do_op(2'b10, 32'h8000_0000, 6'd4);
        @(negedge clk);
        do_op(2'b01, 32'h8000_0000, 6'd4);
        @(negedge clk);
        do_op(2'b00, 32'hFFFF_FFFF, 6'd32);
        @(negedge clk);
        do_op(2'b10, 32'h8000_0001, 6'd40);
        @(negedge clk);
        do_op(2'b10, 32'h8765_4321, 6'd0);
        @(negedge clk);
        do_op(2'b11, 32'h0000_00F0, 6'd27);
        @(negedge clk);
        do_op(2'b01, 32'hDEAD_BEEF, 6'd31);
        @(negedge clk);

        // start pulsed mid-operation is ignored
        issue(2'b00, 32'h0000_0001, 6'd31);
        @(negedge clk);
        @(negedge clk);
        start   = 1'b1;
        mode    = 2'b01;
        data_in = 32'hAAAA_5555;
        shamt   = 6'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);

        // back-to-back from the done cycle
        do_op(2'b00, 32'h0001_0000, 6'd15);
        do_op(2'b10, 32'hF000_000F, 6'd8);
        do_op(2'b01, 32'h1234_5678, 6'd33);
        @(negedge clk);

        // reset in cycle 2 aborts without a done pulse
        issue(2'b00, 32'h0000_0F00, 6'd20);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        // reset pulse with the clock frozen mid-operation has no effect
        do_op(2'b00, 32'h0000_00AB, 6'd24);
        @(negedge clk);
        issue(2'b01, 32'hC000_0000, 6'd30);
        @(negedge clk);
        held   = data_out;
        clk_en = 1'b0;
        #12;
        rst_n = 1'b0;
        #10;
        rst_n = 1'b1;
        #12;
        chk("hold_data_out", data_out, held);
        chk("hold_busy", 32'(busy), 32'd1);
        clk_en = 1'b1;
        repeat (5) @(negedge clk);

        // randomized operations, some back-to-back
        for (int i = 0; i < 200; i++) begin
            rs = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(32, 63))
                                             : 6'($urandom_range(0, 32));
            do_op(2'($urandom), $urandom, rs);
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end

        repeat (10) @(negedge clk);
        chk("drain", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
